frame_sequencer: RTL and testbench
==================================

Name: frame_sequencer

Overview:
Acquisition-level controller that sequences the panel timing generator. It issues frame_start and frame_reset, selects the integration time per frame, and counts completed frames. It supports single, N-frame and continuous acquisition, with optional dark/bright interleave and an inter-frame gap. It sits between the host register block and the timing generator, and supervises the generator with busy/complete timeouts.

Parameters:
BUSY_TIMEOUT, 1024, max cycles from tg_frame_start to tg_frame_busy before a timeout abort
FRAME_TIMEOUT, 32'hFFFF_FFFF, max cycles in WAIT_COMPLETE before a timeout abort
GAP_W, 16, width of the inter-frame gap counter

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
acq_start  input  1  one-cycle start request; honoured only in IDLE
acq_stop  input  1  graceful stop: finish the current frame, then DONE
acq_abort  input  1  immediate abort from any non-IDLE state
cfg_mode  input  2  0=single, 1=N-frame, 2=continuous, 3=reserved (treated as single)
cfg_frame_count  input  16  N for N-frame mode; 0 treated as 1
cfg_integration_time  input  16  bright-frame integration time (ms)
cfg_dark_enable  input  1  alternate bright/dark frames, bright first
cfg_gap_cycles  input  GAP_W  idle cycles between frames
tg_frame_start  output  1  one-cycle frame start to the timing generator
tg_frame_reset  output  1  one-cycle abort to the timing generator
tg_integration_time  output  16  integration time applied to the current frame
tg_frame_busy  input  1  timing generator busy
tg_frame_complete  input  1  timing generator frame-complete pulse
acq_busy  output  1  high in any state except IDLE
frame_done  output  1  one-cycle pulse per counted frame
frame_is_dark  output  1  current/last frame is dark
frames_done  output  16  completed frames this acquisition; saturates at 16'hFFFF
acq_done  output  1  one-cycle pulse on normal completion
acq_aborted  output  1  sticky; cleared by the next accepted acq_start
timeout_err  output  1  sticky; cleared by the next accepted acq_start

Behaviour:
- Reset values: all outputs 0; state IDLE; latched configuration 0.
- States: IDLE, ARM, WAIT_BUSY, WAIT_COMPLETE, GAP, ABORT, DONE.
- IDLE, on acq_start:
  - latch all cfg_* inputs; clear frames_done, acq_aborted, timeout_err, stop_pending; go to ARM next cycle.
  - cfg_* changes after acceptance have no effect until the next acq_start.
- ARM:
  - tg_frame_start=1 for exactly this cycle.
  - tg_integration_time = 0 if the frame is dark, else the latched value; held stable until the next ARM.
  - frame_is_dark = dark_en AND frame index odd. Index = frames_done, counted from 0.
  - go to WAIT_BUSY.
- WAIT_BUSY:
  - tg_frame_busy=1 -> WAIT_COMPLETE.
  - BUSY_TIMEOUT cycles counted from ARM without busy -> set timeout_err, go to ABORT.
- WAIT_COMPLETE, on tg_frame_complete:
  - frame_done pulse; frames_done+1 (saturating).
  - last frame when: single mode; N-frame with frames_done+1 == N; or stop_pending. Last frame -> DONE, otherwise GAP.
  - FRAME_TIMEOUT cycles without complete -> timeout_err, ABORT.
- GAP:
  - count cfg_gap_cycles, and additionally wait for tg_frame_busy=0; then ARM.
  - gap=0 with busy already low: ARM on the next cycle (2-cycle minimum start-to-start after complete).
  - stop_pending in GAP -> DONE.
- acq_stop in any non-IDLE state sets stop_pending. In DONE/ABORT it has no effect. Not applicable to single mode beyond its natural end.
- acq_abort in any state except IDLE/ABORT -> ABORT next cycle.
  - abort has priority over a same-cycle tg_frame_complete; that frame is not counted and no frame_done pulse.
- ABORT:
  - tg_frame_reset=1 on the entry cycle only; acq_aborted=1.
  - wait for tg_frame_busy=0, then IDLE.
  - entered via timeout: timeout_err=1 as well.
- DONE: acq_done=1 for one cycle -> IDLE.
- acq_start while not IDLE is ignored. acq_start and acq_abort together in IDLE: start wins and abort is ignored.
- Continuous mode runs until acq_stop/acq_abort. frames_done holds at 16'hFFFF; counting frames does not wrap.
- Async rst mid-acquisition forces IDLE immediately and does not pulse tg_frame_reset. The timing generator is reset by the same rst.

Test Plan:
- Single mode, integ=5 -> one tg_frame_start pulse with tg_integration_time=5; after complete: frames_done=1, one acq_done pulse, acq_busy low.
- N-frame N=4, dark_enable=1, integ=10, gap=20 -> four starts with integration 10,0,10,0; ≥20 idle cycles between complete and next start; frames_done=4; acq_done.
- Continuous, acq_stop asserted mid-frame 3 -> frame 3 completes; frames_done=3; acq_done; no further tg_frame_start.
- Abort in WAIT_COMPLETE coincident with tg_frame_complete -> tg_frame_reset pulse; frames_done unchanged; acq_aborted=1; IDLE after busy drops; no acq_done.
- tg_frame_busy held 0 after start, BUSY_TIMEOUT=16 -> timeout_err=1 and tg_frame_reset at cycle 16 after ARM; next acq_start clears both flags.
- cfg_frame_count=0 in N-frame mode -> exactly one frame; rst asserted in GAP -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/frame_sequencer.sv
// Acquisition sequencer: drives frame start/reset to the panel timing generator,
// picks per-frame integration time, counts frames and supervises busy/complete timeouts.
module frame_sequencer #(
  parameter int unsigned BUSY_TIMEOUT  = 1024,
  parameter logic [31:0] FRAME_TIMEOUT = 32'hFFFF_FFFF,
  parameter int unsigned GAP_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             acq_start,
  input  logic             acq_stop,
  input  logic             acq_abort,
  input  logic [1:0]       cfg_mode,
  input  logic [15:0]      cfg_frame_count,
  input  logic [15:0]      cfg_integration_time,
  input  logic             cfg_dark_enable,
  input  logic [GAP_W-1:0] cfg_gap_cycles,
  output logic             tg_frame_start,
  output logic             tg_frame_reset,
  output logic [15:0]      tg_integration_time,
  input  logic             tg_frame_busy,
  input  logic             tg_frame_complete,
  output logic             acq_busy,
  output logic             frame_done,
  output logic             frame_is_dark,
  output logic [15:0]      frames_done,
  output logic             acq_done,
  output logic             acq_aborted,
  output logic             timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_WAIT_BUSY, S_WAIT_COMPLETE, S_GAP, S_ABORT, S_DONE
  } state_t;

  localparam logic [31:0] BUSY_LIMIT  = 32'(BUSY_TIMEOUT - 1);
  localparam logic [31:0] FRAME_LIMIT = FRAME_TIMEOUT - 32'd1;

  state_t             state_q, state_d;
  logic [1:0]         mode_q, mode_d;
  logic [15:0]        count_q, count_d;
  logic [15:0]        integ_q, integ_d;
  logic               dark_en_q, dark_en_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [31:0]        tmr_q, tmr_d;
  logic               stop_pending_q, stop_pending_d;
  logic [15:0]        frames_done_q, frames_done_d;
  logic               frame_done_q, frame_done_d;
  logic               frame_is_dark_q, frame_is_dark_d;
  logic [15:0]        tg_integ_q, tg_integ_d;
  logic               tg_reset_q, tg_reset_d;
  logic               aborted_q, aborted_d;
  logic               timeout_q, timeout_d;

  logic               abort_req, stop_req, last_frame, gap_reached, next_dark;
  logic [15:0]        frames_inc, n_eff;
  logic [GAP_W:0]     gap_cnt_inc;

  assign abort_req   = acq_abort && (state_q != S_IDLE) && (state_q != S_ABORT);
  assign stop_req    = stop_pending_q || acq_stop;
  assign n_eff       = (count_q == 16'd0) ? 16'd1 : count_q;
  assign frames_inc  = (frames_done_q == 16'hFFFF) ? 16'hFFFF : frames_done_q + 16'd1;
  // Reserved mode 3 behaves like single.
  assign last_frame  = (mode_q == 2'd0) || (mode_q == 2'd3) ||
                       ((mode_q == 2'd1) && (frames_inc == n_eff)) || stop_req;
  assign gap_cnt_inc = {1'b0, gap_cnt_q} + {{GAP_W{1'b0}}, 1'b1};
  assign gap_reached = gap_cnt_inc >= {1'b0, gap_q};
  assign next_dark   = dark_en_q && frames_done_q[0];

  always_comb begin
    state_d         = state_q;
    mode_d          = mode_q;
    count_d         = count_q;
    integ_d         = integ_q;
    dark_en_d       = dark_en_q;
    gap_d           = gap_q;
    gap_cnt_d       = gap_cnt_q;
    tmr_d           = '0;
    stop_pending_d  = stop_pending_q;
    frames_done_d   = frames_done_q;
    frame_done_d    = 1'b0;
    frame_is_dark_d = frame_is_dark_q;
    tg_integ_d      = tg_integ_q;
    tg_reset_d      = 1'b0;
    aborted_d       = aborted_q;
    timeout_d       = timeout_q;

    if (acq_stop && (state_q inside {S_ARM, S_WAIT_BUSY, S_WAIT_COMPLETE, S_GAP}))
      stop_pending_d = 1'b1;

    // External abort outranks everything, including a same-cycle frame complete.
    if (abort_req) begin
      state_d    = S_ABORT;
      tg_reset_d = 1'b1;
      aborted_d  = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (acq_start) begin
            mode_d          = cfg_mode;
            count_d         = cfg_frame_count;
            integ_d         = cfg_integration_time;
            dark_en_d       = cfg_dark_enable;
            gap_d           = cfg_gap_cycles;
            frames_done_d   = '0;
            aborted_d       = 1'b0;
            timeout_d       = 1'b0;
            stop_pending_d  = 1'b0;
            frame_is_dark_d = 1'b0;
            tg_integ_d      = cfg_integration_time;
            state_d         = S_ARM;
          end
        end
        S_ARM: begin
          tmr_d   = 32'd1;
          state_d = S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (tg_frame_busy) begin
            state_d = S_WAIT_COMPLETE;
          end else if (tmr_q >= BUSY_LIMIT) begin
            state_d    = S_ABORT;
            tg_reset_d = 1'b1;
            aborted_d  = 1'b1;
            timeout_d  = 1'b1;
          end else begin
            tmr_d = tmr_q + 32'd1;
          end
        end
        S_WAIT_COMPLETE: begin
          if (tg_frame_complete) begin
            frame_done_d  = 1'b1;
            frames_done_d = frames_inc;
            gap_cnt_d     = '0;
            state_d       = last_frame ? S_DONE : S_GAP;
          end else if (tmr_q >= FRAME_LIMIT) begin
            state_d    = S_ABORT;
            tg_reset_d = 1'b1;
            aborted_d  = 1'b1;
            timeout_d  = 1'b1;
          end else begin
            tmr_d = tmr_q + 32'd1;
          end
        end
        S_GAP: begin
          if (stop_req) begin
            state_d = S_DONE;
          end else if (gap_reached && !tg_frame_busy) begin
            frame_is_dark_d = next_dark;
            tg_integ_d      = next_dark ? 16'd0 : integ_q;
            state_d         = S_ARM;
          end else if (!gap_reached) begin
            gap_cnt_d = gap_cnt_q + 1'b1;
          end
        end
        S_ABORT: begin
          if (!tg_frame_busy) state_d = S_IDLE;
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      mode_q          <= '0;
      count_q         <= '0;
      integ_q         <= '0;
      dark_en_q       <= 1'b0;
      gap_q           <= '0;
      gap_cnt_q       <= '0;
      tmr_q           <= '0;
      stop_pending_q  <= 1'b0;
      frames_done_q   <= '0;
      frame_done_q    <= 1'b0;
      frame_is_dark_q <= 1'b0;
      tg_integ_q      <= '0;
      tg_reset_q      <= 1'b0;
      aborted_q       <= 1'b0;
      timeout_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      mode_q          <= mode_d;
      count_q         <= count_d;
      integ_q         <= integ_d;
      dark_en_q       <= dark_en_d;
      gap_q           <= gap_d;
      gap_cnt_q       <= gap_cnt_d;
      tmr_q           <= tmr_d;
      stop_pending_q  <= stop_pending_d;
      frames_done_q   <= frames_done_d;
      frame_done_q    <= frame_done_d;
      frame_is_dark_q <= frame_is_dark_d;
      tg_integ_q      <= tg_integ_d;
      tg_reset_q      <= tg_reset_d;
      aborted_q       <= aborted_d;
      timeout_q       <= timeout_d;
    end
  end

  assign tg_frame_start      = (state_q == S_ARM);
  assign tg_frame_reset      = tg_reset_q;
  assign tg_integration_time = tg_integ_q;
  assign acq_busy            = (state_q != S_IDLE);
  assign frame_done          = frame_done_q;
  assign frame_is_dark       = frame_is_dark_q;
  assign frames_done         = frames_done_q;
  assign acq_done            = (state_q == S_DONE);
  assign acq_aborted         = aborted_q;
  assign timeout_err         = timeout_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// Bench for frame_sequencer: plays the timing generator, predicts each acquisition
// from mode/count/stop/abort rules and checks starts, integration times and flags.
module tb_frame_sequencer;

  localparam int          BT = 16;
  localparam logic [31:0] FT = 32'd300;

  logic        clk, rst;
  logic        acq_start, acq_stop, acq_abort;
  logic [1:0]  cfg_mode;
  logic [15:0] cfg_frame_count, cfg_integration_time;
  logic        cfg_dark_enable;
  logic [15:0] cfg_gap_cycles;
  logic        tg_frame_start, tg_frame_reset;
  logic [15:0] tg_integration_time;
  logic        tg_frame_busy, tg_frame_complete;
  logic        acq_busy, frame_done, frame_is_dark, acq_done, acq_aborted, timeout_err;
  logic [15:0] frames_done;

  frame_sequencer #(.BUSY_TIMEOUT(BT), .FRAME_TIMEOUT(FT), .GAP_W(16)) dut (
    .clk(clk), .rst(rst),
    .acq_start(acq_start), .acq_stop(acq_stop), .acq_abort(acq_abort),
    .cfg_mode(cfg_mode), .cfg_frame_count(cfg_frame_count),
    .cfg_integration_time(cfg_integration_time), .cfg_dark_enable(cfg_dark_enable),
    .cfg_gap_cycles(cfg_gap_cycles),
    .tg_frame_start(tg_frame_start), .tg_frame_reset(tg_frame_reset),
    .tg_integration_time(tg_integration_time),
    .tg_frame_busy(tg_frame_busy), .tg_frame_complete(tg_frame_complete),
    .acq_busy(acq_busy), .frame_done(frame_done), .frame_is_dark(frame_is_dark),
    .frames_done(frames_done), .acq_done(acq_done), .acq_aborted(acq_aborted),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int n_start, n_fdone, n_adone, n_reset;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst) begin
      if (tg_frame_start) n_start++;
      if (frame_done)     n_fdone++;
      if (acq_done)       n_adone++;
      if (tg_frame_reset) n_reset++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Frames an acquisition would produce with no stop or abort.
  function automatic int natural_frames(input logic [1:0] mode, input logic [15:0] n);
    if (mode == 2'd1) return (n == 16'd0) ? 1 : int'(n);
    if (mode == 2'd2) return 1 << 30;
    return 1;
  endfunction

  function automatic logic [15:0] exp_integ(input int idx, input logic [15:0] integ, input logic dark);
    return (dark && (idx % 2 == 1)) ? 16'd0 : integ;
  endfunction

  task automatic scramble_cfg();
    cfg_mode             = 2'($urandom);
    cfg_frame_count      = 16'($urandom);
    cfg_integration_time = 16'($urandom);
    cfg_dark_enable      = 1'($urandom);
    cfg_gap_cycles       = 16'($urandom);
  endtask

  task automatic start_acq(input logic [1:0] mode, input logic [15:0] n, input logic [15:0] integ,
                           input logic dark, input logic [15:0] gap, input logic with_abort);
    cfg_mode = mode; cfg_frame_count = n; cfg_integration_time = integ;
    cfg_dark_enable = dark; cfg_gap_cycles = gap;
    n_start = 0; n_fdone = 0; n_adone = 0; n_reset = 0;
    acq_start = 1'b1; acq_abort = with_abort;
    tick();
    acq_start = 1'b0; acq_abort = 1'b0;
    scramble_cfg();
  endtask

  // One full acquisition with the bench acting as timing generator.
  // stop_at / abort_at: frame index during which stop / abort(+complete) is raised, -1 for none.
  task automatic run_acq(input string name, input logic [1:0] mode, input logic [15:0] n,
                         input logic [15:0] integ, input logic dark, input logic [15:0] gap,
                         input int stop_at, input int abort_at, input logic with_abort);
    int  exp_frames, last_c, bound, d0, d1, d2, exp_starts, exp_fd;
    bit  aborted;
    exp_frames = natural_frames(mode, n);
    if (stop_at >= 0 && stop_at + 1 < exp_frames) exp_frames = stop_at + 1;
    aborted = (abort_at >= 0) && (abort_at < exp_frames);
    last_c  = 0;
    start_acq(mode, n, integ, dark, gap, with_abort);
    check({name, " start_pulse"}, 32'(tg_frame_start), 32'd1);
    check({name, " flags_cleared"}, {30'd0, acq_aborted, timeout_err}, 32'd0);
    check({name, " count_cleared"}, 32'(frames_done), 32'd0);
    for (int i = 0; i < 64; i++) begin
      bound = 0;
      while (!tg_frame_start && bound < 200) begin tick(); bound++; end
      if (!tg_frame_start) begin
        check({name, " wait_start"}, 32'(tg_frame_start), 32'd1);
        break;
      end
      check({name, " integ"}, 32'(tg_integration_time), 32'(exp_integ(i, integ, dark)));
      check({name, " dark"}, 32'(frame_is_dark), 32'(dark && (i % 2 == 1)));
      if (i > 0) check({name, " gap_ok"}, 32'((cyc - last_c - 1) >= int'(gap)), 32'd1);
      d0 = $urandom_range(0, 3);
      repeat (d0) tick();
      tg_frame_busy = 1'b1;
      d1 = $urandom_range(2, 6);
      for (int j = 0; j < d1; j++) begin
        acq_stop = (j == 0) && (i == stop_at);
        tick();
      end
      acq_stop = 1'b0;
      tg_frame_complete = 1'b1;
      acq_abort = aborted && (i == abort_at);
      last_c = cyc;
      tick();
      tg_frame_complete = 1'b0;
      acq_abort = 1'b0;
      d2 = $urandom_range(0, 3);
      if (aborted && i == abort_at) begin
        check({name, " abort_reset"}, 32'(tg_frame_reset), 32'd1);
        check({name, " abort_no_fdone"}, 32'(frame_done), 32'd0);
        check({name, " abort_count"}, 32'(frames_done), 32'(i));
        check({name, " abort_flag"}, 32'(acq_aborted), 32'd1);
        repeat (2) tick();
        check({name, " abort_holds"}, 32'(acq_busy), 32'd1);
        tg_frame_busy = 1'b0;
        bound = 0;
        while (acq_busy && bound < 10) begin tick(); bound++; end
        check({name, " abort_idle"}, 32'(acq_busy), 32'd0);
        break;
      end
      check({name, " frame_done"}, 32'(frame_done), 32'd1);
      check({name, " count"}, 32'(frames_done), 32'(i + 1));
      check({name, " acq_done"}, 32'(acq_done), 32'(i + 1 == exp_frames));
      repeat (d2) tick();
      tg_frame_busy = 1'b0;
      if (i + 1 == exp_frames) break;
    end
    repeat (20) tick();
    exp_starts = aborted ? abort_at + 1 : exp_frames;
    exp_fd     = aborted ? abort_at : exp_frames;
    check({name, " idle"}, 32'(acq_busy), 32'd0);
    check({name, " n_start"}, 32'(n_start), 32'(exp_starts));
    check({name, " n_fdone"}, 32'(n_fdone), 32'(exp_fd));
    check({name, " n_acq_done"}, 32'(n_adone), 32'(!aborted));
    check({name, " n_reset"}, 32'(n_reset), 32'(aborted));
    check({name, " final_count"}, 32'(frames_done), 32'(exp_fd));
    $display("acq %s mode=%0d n=%0d integ=%0d dark=%0d gap=%0d stop_at=%0d abort_at=%0d -> frames=%0d aborted=%0d",
             name, mode, n, integ, dark, gap, stop_at, abort_at, exp_fd, aborted);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int s, bound;
    logic [1:0]  r_mode;
    int          r_stop, r_abort;
    rst = 1'b1; acq_start = 1'b0; acq_stop = 1'b0; acq_abort = 1'b0;
    tg_frame_busy = 1'b0; tg_frame_complete = 1'b0;
    scramble_cfg();
    repeat (3) tick();
    check("reset flags", {24'd0, tg_frame_start, tg_frame_reset, acq_busy, frame_done,
                          frame_is_dark, acq_done, acq_aborted, timeout_err}, 32'd0);
    check("reset integ", 32'(tg_integration_time), 32'd0);
    check("reset count", 32'(frames_done), 32'd0);
    rst = 1'b0;
    tick();

    run_acq("single", 2'd0, 16'd0, 16'd5, 1'b0, 16'd0, -1, -1, 1'b0);
    run_acq("nframe_dark", 2'd1, 16'd4, 16'd10, 1'b1, 16'd20, -1, -1, 1'b0);
    run_acq("cont_stop", 2'd2, 16'd0, 16'd7, 1'b0, 16'd3, 2, -1, 1'b0);
    run_acq("abort_cmpl", 2'd1, 16'd4, 16'd9, 1'b1, 16'd2, -1, 2, 1'b0);
    run_acq("n_zero", 2'd1, 16'd0, 16'd33, 1'b0, 16'd0, -1, -1, 1'b0);
    run_acq("mode3", 2'd3, 16'd5, 16'd44, 1'b1, 16'd0, -1, -1, 1'b0);
    run_acq("start_abort", 2'd1, 16'd2, 16'd12, 1'b0, 16'd1, -1, -1, 1'b1);

    // Busy never arrives: timeout abort exactly BT cycles after the start pulse.
    start_acq(2'd0, 16'd0, 16'd3, 1'b0, 16'd0, 1'b0);
    s = cyc; bound = 0;
    while (!tg_frame_reset && bound < 40) begin tick(); bound++; end
    check("busy_to cycles", 32'(cyc - s), 32'(BT));
    check("busy_to flags", {30'd0, timeout_err, acq_aborted}, 32'd3);
    tick();
    check("busy_to idle", 32'(acq_busy), 32'd0);
    $display("acq busy_timeout -> reset after %0d cycles", cyc - s - 1);
    run_acq("after_to", 2'd0, 16'd0, 16'd8, 1'b0, 16'd0, -1, -1, 1'b0);

    // Busy arrives but complete never does.
    start_acq(2'd0, 16'd0, 16'd3, 1'b0, 16'd0, 1'b0);
    s = cyc; tg_frame_busy = 1'b1; bound = 0;
    while (!tg_frame_reset && bound < 400) begin tick(); bound++; end
    check("frame_to cycles", 32'(cyc - s), FT + 32'd2);
    check("frame_to flag", 32'(timeout_err), 32'd1);
    tick();
    check("frame_to holds", 32'(acq_busy), 32'd1);
    tg_frame_busy = 1'b0;
    tick(); tick();
    check("frame_to idle", 32'(acq_busy), 32'd0);
    $display("acq frame_timeout -> reset after %0d cycles", FT + 2);

    for (int k = 0; k < 10; k++) begin
      r_mode  = 2'($urandom_range(0, 3));
      r_stop  = (r_mode == 2'd2) ? int'($urandom_range(0, 4))
              : (($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1);
      r_abort = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
      run_acq($sformatf("rand%0d", k), r_mode, 16'($urandom_range(0, 5)), 16'($urandom),
              1'($urandom), 16'($urandom_range(0, 12)), r_stop, r_abort, 1'b0);
    end

    // Asynchronous reset while waiting in the inter-frame gap.
    start_acq(2'd1, 16'd3, 16'd21, 1'b1, 16'd50, 1'b0);
    tg_frame_busy = 1'b1;
    repeat (3) tick();
    tg_frame_complete = 1'b1;
    tick();
    tg_frame_complete = 1'b0; tg_frame_busy = 1'b0;
    repeat (5) tick();
    check("gap busy", 32'(acq_busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async flags", {24'd0, tg_frame_start, tg_frame_reset, acq_busy, frame_done,
                          frame_is_dark, acq_done, acq_aborted, timeout_err}, 32'd0);
    check("async integ", 32'(tg_integration_time), 32'd0);
    check("async count", 32'(frames_done), 32'd0);
    $display("acq rst_in_gap -> outputs cleared");
    tick();
    rst = 1'b0;
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
